demux_1x2: RTL and testbench
============================

# demux_1x2

1-to-2 demultiplexer: routes a WIDTH-bit input to one of two outputs selected by `sel`. The unselected output is held at zero. The output stage is either combinational or registered, chosen by parameter. Per-channel saturating transfer counters are included for debug and observability. The block sits on datapath fan-out points where one source feeds two consumers.

## Interface
Parameters:
- WIDTH, 1, data width of `in`, `y0` and `y1`.
- REGISTERED, 0, output mode: 0 = outputs are combinational; 1 = outputs are registered on `clk`.
- CNT_W, 8, width of each transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  WIDTH  data to route.
- sel  input  1  0 selects `y0`; 1 selects `y1`.
- in_valid  input  1  qualifies `in` for counting and for registered valids.
- y0  output  WIDTH  channel 0 data.
- y1  output  WIDTH  channel 1 data.
- y0_valid  output  1  equals `in_valid & ~sel`, combinational or registered per REGISTERED.
- y1_valid  output  1  equals `in_valid & sel`, combinational or registered per REGISTERED.
- cnt0  output  CNT_W  number of valid transfers routed to channel 0.
- cnt1  output  CNT_W  number of valid transfers routed to channel 1.

## Operation
- Routing:
  - sel = 0: `y0 = in`, `y1 = 0`.
  - sel = 1: `y1 = in`, `y0 = 0`.
  - The unselected output is always all-zero; it is never high-Z and never holds its old value.
- Valids: `y0_valid = in_valid & ~sel`; `y1_valid = in_valid & sel`. At most one valid is asserted at a time.
- REGISTERED = 0:
  - `y0`, `y1`, `y0_valid` and `y1_valid` are pure combinational functions of `in`, `sel` and `in_valid`.
  - `clk` and `rst_n` do not affect them.
- REGISTERED = 1:
  - The same functions are captured into registers on each rising edge of `clk`.
  - All four register outputs read 0 while `rst_n` = 0.
- Counters:
  - On each rising edge with `in_valid` = 1, the counter of the selected channel increments by 1.
  - Both counters saturate at 2^CNT_W − 1 and do not wrap.
  - With `in_valid` = 0, neither counter changes.
- Reset:
  - `rst_n` low clears `cnt0`, `cnt1` and, when REGISTERED = 1, all output registers. This happens immediately and does not wait for a clock edge.
  - Counters resume counting on the first rising edge after `rst_n` deasserts.
- X on `sel`: no protection in RTL. The bench must drive known values.

## Timing
- REGISTERED = 0: outputs settle combinationally within the same delta cycle as the input change; zero-cycle latency.
- REGISTERED = 1: one-cycle latency; outputs reflect `in`, `sel` and `in_valid` as sampled at the previous rising edge.
- Counters are always registered, in both modes. The counter value reflects transfers up to and including the last rising edge.
- Reset values:
  - `cnt0` = `cnt1` = 0.
  - In registered mode, `y0` = `y1` = 0 and both valids = 0.
- Reset asserted mid-operation:
  - Registered outputs and counters go to 0 asynchronously.
  - Combinational-mode data outputs keep following their inputs.
- Saturation: the counter stays at the maximum value on further valid transfers to that channel; the other channel's counter is unaffected.

## Test plan
- Combinational truth table (REGISTERED = 0, WIDTH = 1), each step held 10 ns:
  - sel = 0, in = 0 -> y0 = 0, y1 = 0.
  - sel = 0, in = 1 -> y0 = 1, y1 = 0.
  - sel = 1, in = 0 -> y0 = 0, y1 = 0.
  - sel = 1, in = 1 -> y0 = 0, y1 = 1.
- Wide data (WIDTH = 8), in = 8'hA5:
  - sel = 0 -> y0 = 8'hA5, y1 = 8'h00.
  - then sel = 1 -> y0 = 8'h00, y1 = 8'hA5.
- Registered mode (REGISTERED = 1): set sel = 1, in = 1, in_valid = 1 before an edge -> y1 = 1 and y1_valid = 1 appear only after that edge, not before.
- Counters: 3 valid cycles with sel = 0, then 2 valid cycles with sel = 1, then 4 cycles with in_valid = 0 -> cnt0 = 3, cnt1 = 2.
- Saturation (CNT_W = 2): 6 valid cycles with sel = 0 -> cnt0 = 3 and holds; cnt1 = 0.
- Asynchronous reset: pull rst_n low between clock edges while counters are nonzero and REGISTERED = 1 -> cnt0, cnt1, y0, y1 and both valids = 0 immediately; counting resumes from 0 after release.

Source files
------------

// File: rtl/demux_1x2.sv
// 1-to-2 demultiplexer with an optional registered output stage and
// per-channel saturating transfer counters for debug visibility.
module demux_1x2 #(
    parameter int WIDTH      = 1,
    parameter int REGISTERED = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_y0;
    logic [WIDTH-1:0] w_y1;
    logic             w_y0_valid;
    logic             w_y1_valid;

    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // NOTE: every output gets a default before the branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_y0       = '0;
        w_y1       = '0;
        w_y0_valid = in_valid & ~sel;
        w_y1_valid = in_valid & sel;
        if (sel) begin
            w_y1 = in;
        end else begin
            w_y0 = in;
        end
    end

    generate
        if (REGISTERED != 0) begin : g_registered
            logic [WIDTH-1:0] r_y0;
            logic [WIDTH-1:0] r_y1;
            logic             r_y0_valid;
            logic             r_y1_valid;

            // NOTE: state is updated with non-blocking assignments and cleared
            // by the asynchronous reset branch, independent of the clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y0       <= '0;
                    r_y1       <= '0;
                    r_y0_valid <= 1'b0;
                    r_y1_valid <= 1'b0;
                end else begin
                    r_y0       <= w_y0;
                    r_y1       <= w_y1;
                    r_y0_valid <= w_y0_valid;
                    r_y1_valid <= w_y1_valid;
                end
            end

            assign y0       = r_y0;
            assign y1       = r_y1;
            assign y0_valid = r_y0_valid;
            assign y1_valid = r_y1_valid;
        end else begin : g_combinational
            assign y0       = w_y0;
            assign y1       = w_y1;
            assign y0_valid = w_y0_valid;
            assign y1_valid = w_y1_valid;
        end
    endgenerate

    // Counters stop at all-ones so a long debug run never reports a small wrapped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (in_valid) begin
            if (sel) begin
                if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
                if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

endmodule

// File: tb/tb_demux_1x2.sv
// Directed bench for demux_1x2: combinational truth table, wide data,
// registered latency, counters, saturation and asynchronous reset.
module tb_demux_1x2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sel      = 1'b0;
    logic       in_valid = 1'b0;
    logic       in1      = 1'b0;
    logic [7:0] in8      = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Combinational, WIDTH = 1
    logic       c1_y0, c1_y1, c1_v0, c1_v1;
    logic [7:0] c1_cnt0, c1_cnt1;
    // Combinational, WIDTH = 8
    logic [7:0] c8_y0, c8_y1;
    logic       c8_v0, c8_v1;
    logic [7:0] c8_cnt0, c8_cnt1;
    // Registered, WIDTH = 1
    logic       r_y0, r_y1, r_v0, r_v1;
    logic [7:0] r_cnt0, r_cnt1;
    // Combinational, WIDTH = 1, CNT_W = 2 (saturation)
    logic       s_y0, s_y1, s_v0, s_v1;
    logic [1:0] s_cnt0, s_cnt1;

    demux_1x2 #(.WIDTH(1), .REGISTERED(0), .CNT_W(8)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .in_valid(in_valid),
        .y0(c1_y0), .y1(c1_y1), .y0_valid(c1_v0), .y1_valid(c1_v1),
        .cnt0(c1_cnt0), .cnt1(c1_cnt1)
    );

    demux_1x2 #(.WIDTH(8), .REGISTERED(0), .CNT_W(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel), .in_valid(in_valid),
        .y0(c8_y0), .y1(c8_y1), .y0_valid(c8_v0), .y1_valid(c8_v1),
        .cnt0(c8_cnt0), .cnt1(c8_cnt1)
    );

    demux_1x2 #(.WIDTH(1), .REGISTERED(1), .CNT_W(8)) dut_r (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .in_valid(in_valid),
        .y0(r_y0), .y1(r_y1), .y0_valid(r_v0), .y1_valid(r_v1),
        .cnt0(r_cnt0), .cnt1(r_cnt1)
    );

    demux_1x2 #(.WIDTH(1), .REGISTERED(0), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .in_valid(in_valid),
        .y0(s_y0), .y1(s_y1), .y0_valid(s_v0), .y1_valid(s_v1),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    typedef struct {
        logic       sel;
        logic       in_valid;
        logic       in1;
        logic [7:0] in8;
        logic       e_y0_1;
        logic       e_y1_1;
        logic [7:0] e_y0_8;
        logic [7:0] e_y1_8;
        logic       e_v0;
        logic       e_v1;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 ns after the following rising edge.
    task automatic step(input logic s, input logic d, input logic v);
        @(negedge clk);
        sel      = s;
        in1      = d;
        in8      = {8{d}};
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          sel  vld  in1  in8    y0_1 y1_1 y0_8   y1_8   v0   v1
        vec[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
        vec[2] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1};
        vec[3] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1};
        vec[4] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
        vec[5] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};

        // Reset state before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_r_y0",   r_y0,   1'b0);
        check("rst_r_y1",   r_y1,   1'b0);
        check("rst_r_v0",   r_v0,   1'b0);
        check("rst_r_v1",   r_v1,   1'b0);
        check("rst_r_cnt0", r_cnt0, 8'd0);
        check("rst_r_cnt1", r_cnt1, 8'd0);
        check("rst_s_cnt0", s_cnt0, 2'd0);

        // Combinational outputs still follow inputs while reset is held
        sel = 1'b1; in8 = 8'h3C; in_valid = 1'b1;
        #1;
        check("rst_c8_y1", c8_y1, 8'h3C);
        check("rst_c8_y0", c8_y0, 8'h00);
        check("rst_c8_v1", c8_v1, 1'b1);

        @(negedge clk);
        sel = 1'b0; in_valid = 1'b0; in1 = 1'b0; in8 = 8'h00;
        rst_n = 1'b1;

        // Combinational truth table, each vector held 10 ns
        for (int i = 0; i < NV; i++) begin
            sel      = vec[i].sel;
            in_valid = vec[i].in_valid;
            in1      = vec[i].in1;
            in8      = vec[i].in8;
            #5;
            check($sformatf("tbl%0d_c1_y0", i), c1_y0, vec[i].e_y0_1);
            check($sformatf("tbl%0d_c1_y1", i), c1_y1, vec[i].e_y1_1);
            check($sformatf("tbl%0d_c8_y0", i), c8_y0, vec[i].e_y0_8);
            check($sformatf("tbl%0d_c8_y1", i), c8_y1, vec[i].e_y1_8);
            check($sformatf("tbl%0d_c1_v0", i), c1_v0, vec[i].e_v0);
            check($sformatf("tbl%0d_c1_v1", i), c1_v1, vec[i].e_v1);
            #5;
        end

        // Registered mode: one idle edge to clear outputs, then one-cycle latency
        step(1'b0, 1'b0, 1'b0);
        check("reg_idle_y0", r_y0, 1'b0);
        check("reg_idle_y1", r_y1, 1'b0);
        @(negedge clk);
        sel = 1'b1; in1 = 1'b1; in_valid = 1'b1;
        #1;
        check("reg_pre_y1", r_y1, 1'b0);
        check("reg_pre_v1", r_v1, 1'b0);
        @(posedge clk);
        #1;
        check("reg_post_y1", r_y1, 1'b1);
        check("reg_post_v1", r_v1, 1'b1);
        check("reg_post_y0", r_y0, 1'b0);
        check("reg_post_v0", r_v0, 1'b0);

        // Asynchronous reset between edges while outputs and counters are nonzero
        #2 rst_n = 1'b0;
        #1;
        check("arst_r_y1",   r_y1,   1'b0);
        check("arst_r_v1",   r_v1,   1'b0);
        check("arst_r_y0",   r_y0,   1'b0);
        check("arst_r_v0",   r_v0,   1'b0);
        check("arst_r_cnt0", r_cnt0, 8'd0);
        check("arst_r_cnt1", r_cnt1, 8'd0);
        check("arst_s_cnt1", s_cnt1, 2'd0);
        check("arst_c1_y1",  c1_y1,  1'b1);
        @(negedge clk);
        sel = 1'b0; in1 = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;

        // Counters: 3 valid to ch0, 2 valid to ch1, 4 idle
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("cnt_ch0_step%0d", k), r_cnt0, k);
        end
        check("cnt_reg_y0", r_y0, 1'b1);
        check("cnt_reg_v0", r_v0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            step(1'b1, 1'b1, 1'b1);
            check($sformatf("cnt_ch1_step%0d", k), r_cnt1, k);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
        check("cnt_r_cnt0", r_cnt0, 8'd3);
        check("cnt_r_cnt1", r_cnt1, 8'd2);
        check("cnt_s_cnt0", s_cnt0, 2'd3);
        check("cnt_s_cnt1", s_cnt1, 2'd2);
        check("idle_r_v0",  r_v0,   1'b0);
        check("idle_r_y0",  r_y0,   1'b1);
        check("idle_r_y1",  r_y1,   1'b0);

        // Saturation with CNT_W = 2
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("sat_s_cnt0_step%0d", k), s_cnt0, (k < 3) ? k : 3);
            check($sformatf("sat_s_cnt1_step%0d", k), s_cnt1, 2'd0);
        end
        check("sat_r_cnt0", r_cnt0, 8'd6);
        step(1'b1, 1'b1, 1'b1);
        check("sat_other_s_cnt1", s_cnt1, 2'd1);
        check("sat_hold_s_cnt0",  s_cnt0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
